// File: rtl/mp3_feeder_pkg.sv
// Shared constants and types for the MP3 data feeder.
// Holds the FSM state encoding and the default FIFO/burst sizes.
package mp3_feeder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_GUARD = 2'd2,
        ST_WAIT  = 2'd3
    } feeder_state_e;

    localparam int DEF_AW    = 4;
    localparam int DEF_BURST = 32;

endpackage

// File: rtl/feeder_fifo.sv
// Byte FIFO for the MP3 feeder.
// Ports: clk_i/rst_ni, flush_i, wr_i/wdata_i, rd_i/rdata_o,
//        count_o/empty_o/full_o (registered), overflow_o (sticky).
module feeder_fifo
    import mp3_feeder_pkg::*;
#(
    parameter int AW = DEF_AW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic          wr_i,
    input  logic [7:0]    wdata_i,
    input  logic          rd_i,
    output logic [7:0]    rdata_o,
    output logic [AW:0]   count_o,
    output logic          empty_o,
    output logic          full_o,
    output logic          overflow_o
);

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [7:0]  mem_q [2**AW];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count_q, count_d;
    logic        empty_q, full_q;
    logic        ovf_q, ovf_d;
    logic        rd_ok, wr_ok;

    assign rd_ok = rd_i && !empty_q;
    // A pop in the same cycle frees the slot the write needs.
    assign wr_ok = wr_i && (!full_q || rd_ok);

    always_comb begin
        wptr_d = wptr_q + (wr_ok ? (AW+1)'(1) : '0);
        rptr_d = rptr_q + (rd_ok ? (AW+1)'(1) : '0);
        ovf_d  = ovf_q | (wr_i && !wr_ok);
        if (flush_i) begin
            // Coincident write is discarded silently.
            wptr_d = '0;
            rptr_d = '0;
            ovf_d  = 1'b0;
        end
        count_d = wptr_d - rptr_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == DEPTH);
            ovf_q   <= ovf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && !flush_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[rptr_q[AW-1:0]];
    assign count_o    = count_q;
    assign empty_o    = empty_q;
    assign full_o     = full_q;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/mp3_feeder.sv
// Feeds bytes from a write FIFO to the MP3 data SPI while DREQ is high.
// Ports: write side (wr_stb/wr_data/flush), SPI side (md_din/md_start/md_rdy),
//        md_dreq (async), status (fifo_*, overflow, busy).
module mp3_feeder
    import mp3_feeder_pkg::*;
#(
    parameter int AW    = DEF_AW,
    parameter int BURST = DEF_BURST
) (
    input  logic          cpu_clock,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          flush,
    input  logic          wr_stb,
    input  logic [7:0]    wr_data,
    input  logic          md_dreq,
    input  logic          md_rdy,
    output logic [7:0]    md_din,
    output logic          md_start,
    output logic          fifo_empty,
    output logic          fifo_full,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic          busy
);

    localparam logic [7:0] BURST_M1 = 8'(BURST - 1);

    feeder_state_e state_q, state_d;
    logic [7:0]    burst_q, burst_d;
    logic [7:0]    din_q, din_d;
    logic [1:0]    dreq_sync_q;
    logic          dreq_s;
    logic          pop;
    logic [7:0]    fifo_rdata;

    assign dreq_s = dreq_sync_q[1];

    feeder_fifo #(
        .AW (AW)
    ) u_fifo (
        .clk_i      (cpu_clock),
        .rst_ni     (rst_n),
        .flush_i    (flush),
        .wr_i       (wr_stb),
        .wdata_i    (wr_data),
        .rd_i       (pop),
        .rdata_o    (fifo_rdata),
        .count_o    (fifo_count),
        .empty_o    (fifo_empty),
        .full_o     (fifo_full),
        .overflow_o (overflow)
    );

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        din_d   = din_q;
        pop     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (enable && dreq_s && !fifo_empty && md_rdy && !flush) begin
                    pop     = 1'b1;
                    din_d   = fifo_rdata;
                    burst_d = BURST_M1;
                    state_d = ST_START;
                end
            end
            ST_START: state_d = ST_GUARD;
            // spi2 may still show rdy=1 here; skip one cycle.
            ST_GUARD: state_d = ST_WAIT;
            ST_WAIT: begin
                if (md_rdy) begin
                    if (burst_q != 8'd0 && enable && !fifo_empty && !flush) begin
                        pop     = 1'b1;
                        din_d   = fifo_rdata;
                        burst_d = burst_q - 8'd1;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            burst_q     <= 8'd0;
            din_q       <= 8'd0;
            dreq_sync_q <= 2'b00;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            din_q       <= din_d;
            dreq_sync_q <= {dreq_sync_q[0], md_dreq};
        end
    end

    assign md_din   = din_q;
    assign md_start = (state_q == ST_START);
    assign busy     = (state_q != ST_IDLE);

endmodule
